// File: rtl/ram_rw_checker.sv
// ram_rw_checker: dual-port RAM fill/readback self-test with error injection and counting
module ram_rw_checker #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              loop_en,
  input  logic              inject_err,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic              ram_we_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_en_b,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [DATA_W-1:0] ram_rd_data
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] seed;
  logic [ADDR_W-1:0] cmp_addr, addr_nxt;
  logic armed, first_seen, pass_err, cmp_v, arm_now, mismatch;
  // next write address, effective injection request and readback compare
  always_comb begin
    addr_nxt = ram_addr_a + 1'b1;
    arm_now  = armed | inject_err;
    mismatch = cmp_v && (ram_rd_data != DATA_W'(cmp_addr) + seed);
  end
  // simple dual-port RAM, one-cycle registered read, contents survive reset
  always_ff @(posedge sys_clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_wr_data;
    if (ram_en_b) ram_rd_data <= mem[ram_addr_b];
  end
  // test sequencer: write pass, read pass, compare pipeline and result bookkeeping
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      pass_cnt       <= '0;
      ram_we_a       <= 1'b0;
      ram_addr_a     <= '0;
      ram_wr_data    <= '0;
      ram_en_b       <= 1'b0;
      ram_addr_b     <= '0;
      seed           <= '0;
      armed          <= 1'b0;
      first_seen     <= 1'b0;
      pass_err       <= 1'b0;
      cmp_v          <= 1'b0;
      cmp_addr       <= '0;
    end else begin
      done     <= 1'b0;
      cmp_v    <= ram_en_b;
      cmp_addr <= ram_addr_b;
      armed    <= arm_now;
      if (mismatch) begin
        err_cnt  <= &err_cnt ? err_cnt : err_cnt + 1'b1;
        pass_err <= 1'b1;
        if (!first_seen) begin
          first_err_addr <= cmp_addr;
          first_seen     <= 1'b1;
        end
      end
      case (state)
        IDLE: if (start) begin
          state          <= WRITE;
          busy           <= 1'b1;
          err_cnt        <= '0;
          pass_cnt       <= '0;
          first_err_addr <= '0;
          first_seen     <= 1'b0;
          pass_err       <= 1'b0;
          seed           <= '0;
          ram_we_a       <= 1'b1;
          ram_addr_a     <= '0;
          ram_wr_data    <= DATA_W'(arm_now);
          armed          <= 1'b0;
        end
        WRITE: if (ram_addr_a == '1) begin
          state      <= READ;
          ram_we_a   <= 1'b0;
          ram_en_b   <= 1'b1;
          ram_addr_b <= '0;
        end else begin
          ram_addr_a  <= addr_nxt;
          ram_wr_data <= (DATA_W'(addr_nxt) + seed) ^ DATA_W'(arm_now);
          armed       <= 1'b0;
        end
        READ: if (ram_addr_b == '1) begin
          state    <= DRAIN;
          ram_en_b <= 1'b0;
        end else ram_addr_b <= ram_addr_b + 1'b1;
        DRAIN: begin
          state    <= DONE;
          done     <= 1'b1;
          pass     <= !(pass_err || mismatch);
          pass_cnt <= pass_cnt + 1'b1;
          seed     <= seed + 1'b1;
        end
        DONE: if (loop_en) begin
          state       <= WRITE;
          pass_err    <= 1'b0;
          ram_we_a    <= 1'b1;
          ram_addr_a  <= '0;
          ram_wr_data <= seed ^ DATA_W'(arm_now);
          armed       <= 1'b0;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_rw_checker.sv
// tb_ram_rw_checker: directed self-checking bench for ram_rw_checker
module tb_ram_rw_checker;
  localparam int N = 64;
  logic sys_clk = 1'b0, sys_rst = 1'b1;
  logic start = 1'b0, loop_en = 1'b0, inject_err = 1'b0;
  logic busy, done, pass, ram_we_a, ram_en_b;
  logic [15:0] err_cnt, pass_cnt;
  logic [5:0] first_err_addr, ram_addr_a, ram_addr_b;
  logic [7:0] ram_wr_data, ram_rd_data;
  logic start2 = 1'b0, loop_en2 = 1'b0, inject_err2 = 1'b0;
  logic busy2, done2, pass2, ram_we_a2, ram_en_b2;
  logic [1:0] err_cnt2, pass_cnt2;
  logic [5:0] first_err_addr2, ram_addr_a2, ram_addr_b2;
  logic [3:0] ram_wr_data2, ram_rd_data2;
  int passed = 0, total = 0;

  always #5 sys_clk = ~sys_clk;

  ram_rw_checker #(.DATA_W(8), .ADDR_W(6), .CNT_W(16)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .loop_en(loop_en), .inject_err(inject_err),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .first_err_addr(first_err_addr),
    .pass_cnt(pass_cnt), .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_wr_data(ram_wr_data),
    .ram_en_b(ram_en_b), .ram_addr_b(ram_addr_b), .ram_rd_data(ram_rd_data));

  ram_rw_checker #(.DATA_W(4), .ADDR_W(6), .CNT_W(2)) dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start2), .loop_en(loop_en2), .inject_err(inject_err2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2), .first_err_addr(first_err_addr2),
    .pass_cnt(pass_cnt2), .ram_we_a(ram_we_a2), .ram_addr_a(ram_addr_a2), .ram_wr_data(ram_wr_data2),
    .ram_en_b(ram_en_b2), .ram_addr_b(ram_addr_b2), .ram_rd_data(ram_rd_data2));

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
  endtask

  initial begin
    tick(2);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_first_err", first_err_addr, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    chk("rst_we_a", ram_we_a, 0);
    chk("rst_en_b", ram_en_b, 0);
    chk("rst_addr_a", ram_addr_a, 0);
    chk("rst_addr_b", ram_addr_b, 0);
    chk("rst_wr_data", ram_wr_data, 0);
    sys_rst = 1'b0;
    tick(1);
    // clean single pass
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("clean_busy_t1", busy, 1);
    chk("clean_we_t1", ram_we_a, 1);
    chk("clean_addr_t1", ram_addr_a, 0);
    chk("clean_data_t1", ram_wr_data, 8'h00);
    tick(5);
    chk("clean_addr5", ram_addr_a, 5);
    chk("clean_data5", ram_wr_data, 8'h05);
    tick(N - 5);
    chk("clean_read_we", ram_we_a, 0);
    chk("clean_read_en", ram_en_b, 1);
    chk("clean_read_addr0", ram_addr_b, 0);
    tick(6);
    chk("clean_rd_addr5", ram_rd_data, 8'h05);
    tick(58);
    chk("clean_done_early", done, 0);
    tick(1);
    chk("clean_done", done, 1);
    chk("clean_pass", pass, 1);
    chk("clean_err_cnt", err_cnt, 0);
    chk("clean_pass_cnt", pass_cnt, 1);
    tick(1);
    chk("clean_idle_busy", busy, 0);
    chk("clean_done_pulse", done, 0);
    // injection armed in IDLE
    inject_err = 1'b1;
    tick(1);
    inject_err = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("inj_word0", ram_wr_data, 8'h01);
    tick(1);
    chk("inj_word1", ram_wr_data, 8'h01);
    tick(2 * N);
    chk("inj_done", done, 1);
    chk("inj_err_cnt", err_cnt, 1);
    chk("inj_first_addr", first_err_addr, 0);
    chk("inj_pass", pass, 0);
    tick(1);
    // three looping passes, loop_en dropped during the third
    loop_en = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(129);
    chk("loop_done1", done, 1);
    chk("loop_cnt1", pass_cnt, 1);
    chk("loop_err_cleared", err_cnt, 0);
    tick(6);
    chk("loop_p2_addr5", ram_addr_a, 5);
    chk("loop_p2_data5", ram_wr_data, 8'h06);
    tick(124);
    chk("loop_done2", done, 1);
    chk("loop_cnt2", pass_cnt, 2);
    tick(10);
    loop_en = 1'b0;
    tick(120);
    chk("loop_done3", done, 1);
    chk("loop_cnt3", pass_cnt, 3);
    chk("loop_pass3", pass, 1);
    tick(1);
    chk("loop_idle", busy, 0);
    // stray start and mid-run reset
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(39);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("stray_start_busy", busy, 1);
    chk("stray_start_addr", ram_addr_a, 40);
    tick(29);
    sys_rst = 1'b1;
    tick(1);
    sys_rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_we", ram_we_a, 0);
    chk("midrst_addr_a", ram_addr_a, 0);
    chk("midrst_data", ram_wr_data, 0);
    chk("midrst_pass", pass, 0);
    chk("midrst_pass_cnt", pass_cnt, 0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2 * N + 1);
    chk("post_rst_done", done, 1);
    chk("post_rst_pass", pass, 1);
    tick(1);
    // narrow data: address truncation and seed wrap
    loop_en2 = 1'b1;
    start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
    tick(17);
    chk("wrap_addr17", ram_addr_a2, 17);
    chk("wrap_data17", ram_wr_data2, 4'h1);
    tick(46);
    chk("wrap_p1_data63", ram_wr_data2, 4'hF);
    tick(130);
    chk("wrap_p2_addr63", ram_addr_a2, 63);
    chk("wrap_p2_data63", ram_wr_data2, 4'h0);
    loop_en2 = 1'b0;
    tick(66);
    chk("wrap_done", done2, 1);
    chk("wrap_pass", pass2, 1);
    chk("wrap_pass_cnt", pass_cnt2, 2);
    tick(1);
    // error counter saturation, one injected word per pass
    inject_err2 = 1'b1;
    tick(1);
    inject_err2 = 1'b0;
    loop_en2 = 1'b1;
    start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
    for (int p = 0; p < 5; p++) begin
      if (p == 4) loop_en2 = 1'b0;
      tick(79);
      inject_err2 = 1'b1;
      tick(1);
      inject_err2 = 1'b0;
      tick(49);
      chk("sat_done", done2, 1);
      chk("sat_err_cnt", err_cnt2, (p + 1 > 3) ? 3 : p + 1);
      chk("sat_pass", pass2, 0);
      tick(1);
    end
    chk("sat_first_addr", first_err_addr2, 0);
    chk("sat_idle", busy2, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
